// File: rtl/rst_sequencer.sv
// rst_sequencer -- power-up reset sequencer for an MMCM + IDELAYCTRL + core/app reset tree.
//
// Waits for MMCM lock, lets the clocks settle, pulses the IDELAYCTRL reset, waits for RDY
// (retrying on timeout), then releases the core reset and, after a further delay, the
// application reset. Lock loss or soft_rst restarts the whole sequence.
//
// Ports
//   sys_clk      in   sequencer clock (sys_clk0 domain)
//   sys_rst_n    in   asynchronous active-low reset
//   mmcm_locked  in   MMCM lock, asynchronous, double-flop synchronised internally
//   idelay_rdy   in   IDELAYCTRL RDY, asynchronous, double-flop synchronised internally
//   soft_rst     in   synchronous, level-sensitive restart request
//   idelay_rst   out  active-high IDELAYCTRL reset
//   core_rst     out  active-high core logic reset
//   app_rst      out  active-high application logic reset
//   seq_done     out  high only in RUN
//   seq_fail     out  high only in FAIL
//   seq_state    out  current state encoding (3 bits)
//   retry_count  out  IDELAYCTRL re-reset attempts in the current sequence (2 bits)

module rst_sequencer #(
   parameter int unsigned SETTLE_CYCLES     = 1024,
   parameter int unsigned IDELAY_RST_CYCLES = 64,
   parameter int unsigned RDY_TIMEOUT       = 4096,
   parameter int unsigned MAX_RETRIES       = 3,
   parameter int unsigned APP_DELAY         = 256
) (
   input  logic       sys_clk,
   input  logic       sys_rst_n,
   input  logic       mmcm_locked,
   input  logic       idelay_rdy,
   input  logic       soft_rst,
   output logic       idelay_rst,
   output logic       core_rst,
   output logic       app_rst,
   output logic       seq_done,
   output logic       seq_fail,
   output logic [2:0] seq_state,
   output logic [1:0] retry_count
);

   // Counter is sized for the longest dwell of any timed state.
   localparam int unsigned Max01     = (SETTLE_CYCLES > IDELAY_RST_CYCLES) ?
                                       SETTLE_CYCLES : IDELAY_RST_CYCLES;
   localparam int unsigned Max23     = (RDY_TIMEOUT > APP_DELAY) ? RDY_TIMEOUT : APP_DELAY;
   localparam int unsigned MaxCycles = (Max01 > Max23) ? Max01 : Max23;
   localparam int unsigned CntW      = $clog2(MaxCycles + 1);

   typedef logic [CntW-1:0] cnt_t;

   localparam cnt_t       SettleLast  = cnt_t'(SETTLE_CYCLES - 1);
   localparam cnt_t       IdlyLast    = cnt_t'(IDELAY_RST_CYCLES - 1);
   localparam cnt_t       TimeoutLast = cnt_t'(RDY_TIMEOUT - 1);
   localparam cnt_t       AppLast     = cnt_t'(APP_DELAY - 1);
   localparam cnt_t       CntMax      = cnt_t'(MaxCycles);
   localparam logic [1:0] RetryMax    = 2'(MAX_RETRIES);

   typedef enum logic [2:0] {
      StWaitLock = 3'd0,
      StSettle   = 3'd1,
      StIdlyRst  = 3'd2,
      StWaitRdy  = 3'd3,
      StCoreRel  = 3'd4,
      StRun      = 3'd5,
      StFail     = 3'd6
   } state_e;

   state_e     state_q, state_d;
   cnt_t       cnt_q, cnt_d;
   logic [1:0] retry_q, retry_d;
   logic [1:0] lock_sync_q, rdy_sync_q;
   logic       lock_s, rdy_s;
   logic       idelay_rst_q, idelay_rst_d;
   logic       core_rst_q, core_rst_d;
   logic       app_rst_q, app_rst_d;
   logic       seq_done_q, seq_done_d;
   logic       seq_fail_q, seq_fail_d;

   assign lock_s = lock_sync_q[1];
   assign rdy_s  = rdy_sync_q[1];

   // Next state and retry bookkeeping. Lock loss outranks soft_rst, which outranks the rest;
   // both land in WaitLock, so their relative order only matters for readability.
   always_comb begin
      state_d = state_q;
      retry_d = retry_q;
      if ((state_q != StWaitLock && !lock_s) || soft_rst) begin
         state_d = StWaitLock;
         retry_d = 2'd0;
      end else begin
         case (state_q)
            StWaitLock: begin
               if (lock_s) state_d = StSettle;
            end
            StSettle: begin
               if (cnt_q == SettleLast) state_d = StIdlyRst;
            end
            StIdlyRst: begin
               if (cnt_q == IdlyLast) state_d = StWaitRdy;
            end
            StWaitRdy: begin
               // RDY arriving on the timeout edge wins over the retry.
               if (rdy_s) begin
                  state_d = StCoreRel;
               end else if (cnt_q == TimeoutLast) begin
                  if (retry_q < RetryMax) begin
                     retry_d = retry_q + 2'd1;
                     state_d = StIdlyRst;
                  end else begin
                     state_d = StFail;
                  end
               end
            end
            StCoreRel: begin
               if (!rdy_s) begin
                  state_d = StIdlyRst;
               end else if (cnt_q == AppLast) begin
                  state_d = StRun;
               end
            end
            StRun: begin
               if (!rdy_s) state_d = StIdlyRst;
            end
            StFail: begin
               state_d = StFail;
            end
            default: begin
               state_d = StWaitLock;
               retry_d = 2'd0;
            end
         endcase
      end
   end

   // Dwell counter restarts on every state change and parks at its maximum in untimed states.
   always_comb begin
      cnt_d = cnt_q;
      if (state_d != state_q) begin
         cnt_d = '0;
      end else if (cnt_q != CntMax) begin
         cnt_d = cnt_q + cnt_t'(1);
      end
   end

   // Outputs are decoded from the next state and registered, so they line up with state_q.
   always_comb begin
      idelay_rst_d = state_d inside {StWaitLock, StSettle, StIdlyRst, StFail};
      core_rst_d   = !(state_d inside {StCoreRel, StRun});
      app_rst_d    = (state_d != StRun);
      seq_done_d   = (state_d == StRun);
      seq_fail_d   = (state_d == StFail);
   end

   always_ff @(posedge sys_clk or negedge sys_rst_n) begin
      if (!sys_rst_n) begin
         lock_sync_q  <= 2'b00;
         rdy_sync_q   <= 2'b00;
         state_q      <= StWaitLock;
         cnt_q        <= '0;
         retry_q      <= 2'd0;
         idelay_rst_q <= 1'b1;
         core_rst_q   <= 1'b1;
         app_rst_q    <= 1'b1;
         seq_done_q   <= 1'b0;
         seq_fail_q   <= 1'b0;
      end else begin
         lock_sync_q  <= {lock_sync_q[0], mmcm_locked};
         rdy_sync_q   <= {rdy_sync_q[0], idelay_rdy};
         state_q      <= state_d;
         cnt_q        <= cnt_d;
         retry_q      <= retry_d;
         idelay_rst_q <= idelay_rst_d;
         core_rst_q   <= core_rst_d;
         app_rst_q    <= app_rst_d;
         seq_done_q   <= seq_done_d;
         seq_fail_q   <= seq_fail_d;
      end
   end

   assign idelay_rst  = idelay_rst_q;
   assign core_rst    = core_rst_q;
   assign app_rst     = app_rst_q;
   assign seq_done    = seq_done_q;
   assign seq_fail    = seq_fail_q;
   assign seq_state   = state_q;
   assign retry_count = retry_q;

endmodule

// File: tb/tb_rst_sequencer.sv
// Bench for rst_sequencer with small parameters. A behavioural model (dwell table, retry
// tally, two-stage input delay) is stepped on every clock edge and the DUT outputs are
// compared against it, plus targeted scenario checks.

module tb_rst_sequencer;

   localparam int unsigned SettleN  = 8;
   localparam int unsigned IdlyN    = 4;
   localparam int unsigned TimeoutN = 16;
   localparam int unsigned RetriesN = 2;
   localparam int unsigned AppN     = 5;

   localparam int StWaitLock = 0;
   localparam int StSettle   = 1;
   localparam int StIdlyRst  = 2;
   localparam int StWaitRdy  = 3;
   localparam int StCoreRel  = 4;
   localparam int StRun      = 5;
   localparam int StFail     = 6;

   // {seq_state, retry_count, idelay_rst, core_rst, app_rst, seq_done, seq_fail}
   localparam logic [9:0] RstVec = 10'b000_00_11100;

   logic       sys_clk     = 1'b0;
   logic       sys_rst_n   = 1'b1;
   logic       mmcm_locked = 1'b0;
   logic       idelay_rdy  = 1'b0;
   logic       soft_rst    = 1'b0;
   logic       idelay_rst;
   logic       core_rst;
   logic       app_rst;
   logic       seq_done;
   logic       seq_fail;
   logic [2:0] seq_state;
   logic [1:0] retry_count;

   always #5 sys_clk = ~sys_clk;

   rst_sequencer #(
      .SETTLE_CYCLES    (SettleN),
      .IDELAY_RST_CYCLES(IdlyN),
      .RDY_TIMEOUT      (TimeoutN),
      .MAX_RETRIES      (RetriesN),
      .APP_DELAY        (AppN)
   ) dut (
      .sys_clk    (sys_clk),
      .sys_rst_n  (sys_rst_n),
      .mmcm_locked(mmcm_locked),
      .idelay_rdy (idelay_rdy),
      .soft_rst   (soft_rst),
      .idelay_rst (idelay_rst),
      .core_rst   (core_rst),
      .app_rst    (app_rst),
      .seq_done   (seq_done),
      .seq_fail   (seq_fail),
      .seq_state  (seq_state),
      .retry_count(retry_count)
   );

   int n_checks = 0;
   int n_pass   = 0;

   // Reference model state
   int m_state, m_elapsed, m_retry;
   bit m_lock_p1, m_lock_s, m_rdy_p1, m_rdy_s;

   function automatic int dwell(int st);
      case (st)
         StSettle:  return SettleN;
         StIdlyRst: return IdlyN;
         StWaitRdy: return TimeoutN;
         StCoreRel: return AppN;
         default:   return 0;
      endcase
   endfunction

   task automatic model_reset();
      m_state   = StWaitLock;
      m_elapsed = 0;
      m_retry   = 0;
      m_lock_p1 = 0;
      m_lock_s  = 0;
      m_rdy_p1  = 0;
      m_rdy_s   = 0;
   endtask

   task automatic model_edge();
      int ns;
      bit expired;
      if (!sys_rst_n) begin
         model_reset();
         return;
      end
      ns = m_state;
      expired = (dwell(m_state) != 0) && (m_elapsed + 1 >= dwell(m_state));
      if ((m_state != StWaitLock && !m_lock_s) || soft_rst) begin
         ns = StWaitLock;
         m_retry = 0;
      end else begin
         case (m_state)
            StWaitLock: if (m_lock_s) ns = StSettle;
            StSettle:   if (expired) ns = StIdlyRst;
            StIdlyRst:  if (expired) ns = StWaitRdy;
            StWaitRdy: begin
               if (m_rdy_s) ns = StCoreRel;
               else if (expired) begin
                  if (m_retry < int'(RetriesN)) begin
                     m_retry = m_retry + 1;
                     ns = StIdlyRst;
                  end else begin
                     ns = StFail;
                  end
               end
            end
            StCoreRel: begin
               if (!m_rdy_s) ns = StIdlyRst;
               else if (expired) ns = StRun;
            end
            StRun: if (!m_rdy_s) ns = StIdlyRst;
            default: ;
         endcase
      end
      m_elapsed = (ns != m_state) ? 0 : m_elapsed + 1;
      m_state   = ns;
      m_lock_s  = m_lock_p1;
      m_lock_p1 = mmcm_locked;
      m_rdy_s   = m_rdy_p1;
      m_rdy_p1  = idelay_rdy;
   endtask

   function automatic logic [9:0] exp_vec();
      logic idly, core, app, done, fail;
      idly = (m_state inside {StWaitLock, StSettle, StIdlyRst, StFail});
      core = !(m_state inside {StCoreRel, StRun});
      app  = (m_state != StRun);
      done = (m_state == StRun);
      fail = (m_state == StFail);
      return {3'(m_state), 2'(m_retry), idly, core, app, done, fail};
   endfunction

   function automatic logic [9:0] dut_vec();
      return {seq_state, retry_count, idelay_rst, core_rst, app_rst, seq_done, seq_fail};
   endfunction

   // Advance one clock; model steps on the edge, outputs are sampled 1 time unit later.
   task automatic tick();
      @(posedge sys_clk);
      model_edge();
      #1;
   endtask

   task automatic test_reset();
      model_reset();
      #2 sys_rst_n = 1'b0;
      #1;
      n_checks++;
      if (dut_vec() !== RstVec)
         $display("FAIL reset_async got=%b exp=%b", dut_vec(), RstVec);
      else n_pass++;
      repeat (3) tick();
      n_checks++;
      if (dut_vec() !== exp_vec())
         $display("FAIL reset_hold got=%b exp=%b", dut_vec(), exp_vec());
      else n_pass++;
      sys_rst_n = 1'b1;
      repeat (4) begin
         tick();
         n_checks++;
         if (dut_vec() !== exp_vec())
            $display("FAIL reset_idle got=%b exp=%b", dut_vec(), exp_vec());
         else n_pass++;
      end
   endtask

   task automatic test_nominal();
      int  settle_n, idly_n, core_fall, app_fall, done_rise, rdy_cd;
      bit  p_idly, p_core, p_app, p_done, finished;
      settle_n = 0; idly_n = 0; core_fall = -1; app_fall = -1; done_rise = -1;
      rdy_cd = -1; finished = 0;
      p_idly = idelay_rst; p_core = core_rst; p_app = app_rst; p_done = seq_done;
      mmcm_locked = 1'b1;
      idelay_rdy  = 1'b0;
      for (int cyc = 0; cyc < 200 && !finished; cyc++) begin
         tick();
         n_checks++;
         if (dut_vec() !== exp_vec())
            $display("FAIL nominal_step cyc=%0d got=%b exp=%b", cyc, dut_vec(), exp_vec());
         else n_pass++;
         if (rdy_cd > 0) begin
            rdy_cd--;
            if (rdy_cd == 0) idelay_rdy = 1'b1;
         end
         if (seq_state == 3'd1) settle_n++;
         if (seq_state == 3'd2) idly_n++;
         if (p_idly && !idelay_rst) rdy_cd = 3;
         if (p_core && !core_rst) core_fall = cyc;
         if (p_app && !app_rst) app_fall = cyc;
         if (!p_done && seq_done) begin
            done_rise = cyc;
            finished  = 1;
         end
         p_idly = idelay_rst; p_core = core_rst; p_app = app_rst; p_done = seq_done;
      end
      n_checks++;
      if (!finished) $display("FAIL nominal_done got=timeout exp=seq_done");
      else n_pass++;
      n_checks++;
      if (settle_n != int'(SettleN))
         $display("FAIL nominal_settle got=%0d exp=%0d", settle_n, SettleN);
      else n_pass++;
      n_checks++;
      if (idly_n != int'(IdlyN))
         $display("FAIL nominal_idly got=%0d exp=%0d", idly_n, IdlyN);
      else n_pass++;
      n_checks++;
      if (core_fall < 0 || app_fall - core_fall != int'(AppN))
         $display("FAIL nominal_app_delay got=%0d exp=%0d", app_fall - core_fall, AppN);
      else n_pass++;
      n_checks++;
      if (done_rise != app_fall)
         $display("FAIL nominal_done_align got=%0d exp=%0d", done_rise, app_fall);
      else n_pass++;
   endtask

   task automatic test_lock_loss();
      bit reached;
      reached = 0;
      mmcm_locked = 1'b0;
      for (int i = 0; i < 10 && !reached; i++) begin
         tick();
         n_checks++;
         if (dut_vec() !== exp_vec())
            $display("FAIL lockloss_step got=%b exp=%b", dut_vec(), exp_vec());
         else n_pass++;
         if (seq_state == 3'd0) reached = 1;
      end
      n_checks++;
      if (!reached || {idelay_rst, core_rst, app_rst, retry_count} !== 5'b111_00)
         $display("FAIL lockloss_resets got=%b exp=%b",
                  {idelay_rst, core_rst, app_rst, retry_count}, 5'b111_00);
      else n_pass++;
      mmcm_locked = 1'b1;
      reached = 0;
      for (int i = 0; i < 100 && !reached; i++) begin
         tick();
         n_checks++;
         if (dut_vec() !== exp_vec())
            $display("FAIL relock_step got=%b exp=%b", dut_vec(), exp_vec());
         else n_pass++;
         if (seq_done) reached = 1;
      end
      n_checks++;
      if (!reached) $display("FAIL relock_done got=timeout exp=seq_done");
      else n_pass++;
   endtask

   task automatic test_timeout_fail();
      int run_len, n_runs;
      bit in_fail;
      run_len = 0; n_runs = 0; in_fail = 0;
      idelay_rdy = 1'b0;
      for (int i = 0; i < 300 && !in_fail; i++) begin
         tick();
         n_checks++;
         if (dut_vec() !== exp_vec())
            $display("FAIL timeout_step got=%b exp=%b", dut_vec(), exp_vec());
         else n_pass++;
         if (seq_state == 3'd3) begin
            run_len++;
         end else if (run_len != 0) begin
            n_runs++;
            n_checks++;
            if (run_len != int'(TimeoutN))
               $display("FAIL timeout_len got=%0d exp=%0d", run_len, TimeoutN);
            else n_pass++;
            if (seq_state == 3'd2) begin
               n_checks++;
               if (retry_count !== 2'(n_runs))
                  $display("FAIL timeout_retry got=%0d exp=%0d", retry_count, n_runs);
               else n_pass++;
            end
            run_len = 0;
         end
         if (seq_fail) in_fail = 1;
      end
      n_checks++;
      if (!in_fail || n_runs != 3)
         $display("FAIL timeout_to_fail got=runs%0d exp=runs3", n_runs);
      else n_pass++;
      n_checks++;
      if ({seq_state, retry_count, idelay_rst, seq_fail} !== 7'b110_10_1_1)
         $display("FAIL fail_outputs got=%b exp=%b",
                  {seq_state, retry_count, idelay_rst, seq_fail}, 7'b110_10_1_1);
      else n_pass++;
   endtask

   task automatic test_soft_fail();
      repeat (5) begin
         tick();
         n_checks++;
         if (dut_vec() !== exp_vec())
            $display("FAIL fail_hold got=%b exp=%b", dut_vec(), exp_vec());
         else n_pass++;
      end
      soft_rst = 1'b1;
      tick();
      soft_rst = 1'b0;
      n_checks++;
      if ({seq_state, seq_fail, retry_count} !== 6'b000_0_00)
         $display("FAIL soft_from_fail got=%b exp=%b",
                  {seq_state, seq_fail, retry_count}, 6'b000_0_00);
      else n_pass++;
      soft_rst = 1'b1;
      repeat (8) begin
         tick();
         n_checks++;
         if (seq_state !== 3'd0 || dut_vec() !== exp_vec())
            $display("FAIL soft_hold got=%b exp=%b", dut_vec(), exp_vec());
         else n_pass++;
      end
      soft_rst = 1'b0;
   endtask

   task automatic test_coincide();
      bit found;
      found = 0;
      idelay_rdy = 1'b0;
      for (int i = 0; i < 200 && !found; i++) begin
         tick();
         n_checks++;
         if (dut_vec() !== exp_vec())
            $display("FAIL coincide_step got=%b exp=%b", dut_vec(), exp_vec());
         else n_pass++;
         if (seq_state == 3'd3 && retry_count == 2'd1) found = 1;
      end
      n_checks++;
      if (!found) $display("FAIL coincide_setup got=timeout exp=wait_rdy_retry1");
      else n_pass++;
      // rdy driven now is seen by the state logic three edges later: the 16th WAIT_RDY edge.
      repeat (13) tick();
      idelay_rdy = 1'b1;
      repeat (2) tick();
      n_checks++;
      if (seq_state !== 3'd3)
         $display("FAIL coincide_pre got=%0d exp=3", seq_state);
      else n_pass++;
      tick();
      n_checks++;
      if ({seq_state, retry_count} !== 5'b100_01 || dut_vec() !== exp_vec())
         $display("FAIL coincide_core got=%b exp=%b", {seq_state, retry_count}, 5'b100_01);
      else n_pass++;
   endtask

   task automatic test_rdy_drop_core();
      bit reached;
      logic [2:0] prev;
      reached = 0;
      tick();
      prev = seq_state;
      idelay_rdy = 1'b0;
      for (int i = 0; i < 8 && !reached; i++) begin
         tick();
         n_checks++;
         if (dut_vec() !== exp_vec())
            $display("FAIL rdydrop_step got=%b exp=%b", dut_vec(), exp_vec());
         else n_pass++;
         if (seq_state == 3'd2) reached = 1;
         else prev = seq_state;
      end
      n_checks++;
      if (!reached || prev !== 3'd4 || core_rst !== 1'b1 || retry_count !== 2'd1)
         $display("FAIL rdydrop_core got=prev%0d core%b retry%0d exp=prev4 core1 retry1",
                  prev, core_rst, retry_count);
      else n_pass++;
   endtask

   task automatic test_async_reset();
      bit reached;
      reached = 0;
      idelay_rdy = 1'b1;
      for (int i = 0; i < 60 && !reached; i++) begin
         tick();
         n_checks++;
         if (dut_vec() !== exp_vec())
            $display("FAIL arst_setup_step got=%b exp=%b", dut_vec(), exp_vec());
         else n_pass++;
         if (seq_state == 3'd4) reached = 1;
      end
      n_checks++;
      if (!reached) $display("FAIL arst_setup got=timeout exp=core_rel");
      else n_pass++;
      repeat (2) tick();
      #2 sys_rst_n = 1'b0;
      model_reset();
      #1;
      n_checks++;
      if (dut_vec() !== RstVec)
         $display("FAIL arst_mid_core got=%b exp=%b", dut_vec(), RstVec);
      else n_pass++;
      repeat (3) tick();
      sys_rst_n = 1'b1;
      reached = 0;
      for (int i = 0; i < 100 && !reached; i++) begin
         tick();
         n_checks++;
         if (dut_vec() !== exp_vec())
            $display("FAIL arst_restart_step got=%b exp=%b", dut_vec(), exp_vec());
         else n_pass++;
         if (seq_done) reached = 1;
      end
      n_checks++;
      if (!reached) $display("FAIL arst_restart got=timeout exp=seq_done");
      else n_pass++;
   endtask

   task automatic test_random();
      for (int i = 0; i < 2500; i++) begin
         if (!sys_rst_n) begin
            sys_rst_n = 1'b1;
         end else if ($urandom_range(999, 0) < 2) begin
            sys_rst_n = 1'b0;
            model_reset();
         end
         if (mmcm_locked) begin
            if ($urandom_range(999, 0) < 5) mmcm_locked = 1'b0;
         end else if ($urandom_range(999, 0) < 100) begin
            mmcm_locked = 1'b1;
         end
         if (idelay_rdy) begin
            if ($urandom_range(999, 0) < 15) idelay_rdy = 1'b0;
         end else if ($urandom_range(999, 0) < 40) begin
            idelay_rdy = 1'b1;
         end
         soft_rst = ($urandom_range(999, 0) < 5);
         tick();
         n_checks++;
         if (dut_vec() !== exp_vec())
            $display("FAIL random_step i=%0d got=%b exp=%b", i, dut_vec(), exp_vec());
         else n_pass++;
      end
      soft_rst  = 1'b0;
      sys_rst_n = 1'b1;
   endtask

   initial begin
      test_reset();
      test_nominal();
      test_lock_loss();
      test_timeout_fail();
      test_soft_fail();
      test_coincide();
      test_rdy_drop_core();
      test_async_reset();
      test_random();
      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

   initial begin
      #2_000_000;
      $display("FAIL watchdog got=timeout exp=finish");
      $fatal(1, "watchdog expired");
   end

endmodule
